// File: rtl/ahb_data_mem_slave.sv
// AHB-lite style data-memory responder: 64-bit word RAM, fixed wait states, one transfer at a time.
// Optional out-of-range error response enabled by defining DMEM_RANGE_CHECK_EN.
module ahb_data_mem_slave #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] HADDR,
  input  logic        HTRANS,
  input  logic        HWRITE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [63:0]           mem [0:(1<<DEPTH_LOG2)-1];

  logic [63:0]           off;
  logic [DEPTH_LOG2-1:0] idx_a;
  logic                  in_range;
  logic                  commit;
  logic                  unused_bits;

  assign off    = HADDR - BASE_ADDR;
  assign idx_a  = off[DEPTH_LOG2+2:3];
  assign commit = (state == DATA) && wr_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range    = (HADDR >= BASE_ADDR) && (off[63:DEPTH_LOG2+3] == '0);
  assign unused_bits = ^off[2:0];
`else
  // Upper offset bits are discarded so the index wraps modulo the depth.
  assign in_range    = 1'b1;
  assign unused_bits = ^{off[63:DEPTH_LOG2+3], off[2:0]};
`endif

  // RAM contents survive reset; only a write that reaches its DATA edge lands.
  always_ff @(posedge CLK) begin
    if (commit) mem[idx_q] <= HWDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      HREADY <= 1'b1;
      HRESP  <= 1'b0;
      HRDATA <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 4'd0) begin
            state  <= DATA;
            HREADY <= 1'b1;
            if (!wr_q) HRDATA <= mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ERR1: begin
          state  <= ERR2;
          HREADY <= 1'b1;
          HRDATA <= '0;
        end
        default: begin
          // IDLE, DATA and ERR2 all have HREADY=1, so HTRANS alone accepts.
          if (HTRANS) begin
            idx_q <= idx_a;
            wr_q  <= HWRITE;
            if (!in_range) begin
              state  <= ERR1;
              HREADY <= 1'b0;
              HRESP  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state  <= WAIT;
              HREADY <= 1'b0;
              HRESP  <= 1'b0;
              cnt    <= 4'(WAIT_STATES - 1);
            end else begin
              state  <= DATA;
              HREADY <= 1'b1;
              HRESP  <= 1'b0;
              // Forward the write being committed this edge to a same-index read.
              if (!HWRITE)
                HRDATA <= (commit && idx_q == idx_a) ? HWDATA : mem[idx_a];
            end
          end else begin
            state  <= IDLE;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_data_mem_slave.sv
// Randomized self-checking bench: three responders (0, 1 and 3 wait states) against a word-array model.
module tb_ahb_data_mem_slave;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] haddr  [NI];
  logic        htrans [NI];
  logic        hwrite [NI];
  logic [63:0] hwdata [NI];
  logic [63:0] hrdata [NI];
  logic        hready [NI];
  logic        hresp  [NI];

  logic [63:0] mem_m [NI][DEPTH];
  logic [63:0] pool  [NI][8];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    ahb_data_mem_slave #(.DEPTH_LOG2(10), .BASE_ADDR(64'h0), .WAIT_STATES(W)) dut (
      .CLK(clk), .RST_N(rst_n), .HADDR(haddr[g]), .HTRANS(htrans[g]), .HWRITE(hwrite[g]),
      .HWDATA(hwdata[g]), .HRDATA(hrdata[g]), .HREADY(hready[g]), .HRESP(hresp[g]));
  end

  function automatic int wsof(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts HREADY-low cycles seen at negedges until the data phase completes.
  task automatic wait_rdy(input int i, input bit err, output int n);
    n = 0;
    @(negedge clk);
    while (!hready[i] && n < 40) begin
      chk($sformatf("wait_resp%0d", i), 64'(hresp[i]), 64'(err));
      n++;
      @(negedge clk);
    end
  endtask

  task automatic xfer(input int i, input bit wr, input logic [63:0] a, input logic [63:0] wd);
    bit err;
    int n;
    err = RANGE_EN && (a >= 64'(8 * DEPTH));
    @(negedge clk);
    chk($sformatf("rdy_idle%0d", i), 64'(hready[i]), 64'd1);
    htrans[i] = 1'b1; hwrite[i] = wr; haddr[i] = a;
    @(posedge clk); #1;
    htrans[i] = 1'b0; hwrite[i] = $urandom_range(1); haddr[i] = {$urandom, $urandom};
    hwdata[i] = wd;
    wait_rdy(i, err, n);
    chk($sformatf("lat%0d", i), 64'(n), err ? 64'd1 : 64'(wsof(i)));
    chk($sformatf("resp%0d", i), 64'(hresp[i]), 64'(err));
    if (err) chk($sformatf("err_rdata%0d", i), hrdata[i], 64'h0);
    else if (!wr) chk($sformatf("rdata%0d_%h", i, a), hrdata[i], mem_m[i][widx(a)]);
    if (wr && !err) mem_m[i][widx(a)] = wd;
    if (err) begin
      @(negedge clk);
      chk($sformatf("err_done%0d", i), 64'(hresp[i]), 64'd0);
    end
  endtask

  // Write immediately followed by a pipelined read whose address phase overlaps the write's data phase.
  task automatic b2b(input int i, input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] ra);
    int n;
    @(negedge clk);
    htrans[i] = 1'b1; hwrite[i] = 1'b1; haddr[i] = wa;
    @(posedge clk); #1;
    hwdata[i] = wd; hwrite[i] = 1'b0; haddr[i] = ra;
    wait_rdy(i, 1'b0, n);
    chk($sformatf("b2b_wlat%0d", i), 64'(n), 64'(wsof(i)));
    mem_m[i][widx(wa)] = wd;
    @(posedge clk); #1;
    htrans[i] = 1'b0;
    wait_rdy(i, 1'b0, n);
    chk($sformatf("b2b_rlat%0d", i), 64'(n), 64'(wsof(i)));
    chk($sformatf("b2b_rdata%0d", i), hrdata[i], mem_m[i][widx(ra)]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NI; i++) begin
      haddr[i] = '0; htrans[i] = 1'b0; hwrite[i] = 1'b0; hwdata[i] = '0;
    end
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_rdy%0d", i), 64'(hready[i]), 64'd1);
      chk($sformatf("rst_resp%0d", i), 64'(hresp[i]), 64'd0);
      chk($sformatf("rst_rdata%0d", i), hrdata[i], 64'h0);
    end
    rst_n = 1'b1;

    // Directed: write/read on the one-wait instance, bypass on the zero-wait one.
    xfer(1, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
    xfer(1, 1'b0, 64'h10, 64'h0);
    chk("wr_rd_value", hrdata[1], 64'hDEADBEEF_CAFEF00D);
    b2b(0, 64'h8, 64'h1234, 64'h8);
    chk("bypass_value", hrdata[0], 64'h1234);

    // Wrap or error at one past the top word; index 0 seeded first.
    xfer(1, 1'b1, 64'h0, 64'h5A5A_0000_1111_2222);
    xfer(1, 1'b1, 64'h2000, 64'hA5);
    xfer(1, 1'b0, 64'h0, 64'h0);
    xfer(1, 1'b0, 64'h2000, 64'h0);
    xfer(1, 1'b0, 64'h3FF8, 64'h0);

    // Reset in the second wait cycle of a write must not commit it.
    xfer(2, 1'b1, 64'h18, 64'h0BAD_F00D);
    @(negedge clk);
    htrans[2] = 1'b1; hwrite[2] = 1'b1; haddr[2] = 64'h18;
    @(posedge clk); #1;
    htrans[2] = 1'b0; hwdata[2] = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 64'(hready[2]), 64'd1);
    chk("midrst_rdata", hrdata[2], 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, 64'h18, 64'h0);
    chk("midrst_keep", hrdata[2], 64'h0BAD_F00D);

    // Random traffic over a small initialized pool per instance.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) begin
        pool[i][k] = (64'($urandom_range(DEPTH - 1)) << 3) | 64'($urandom_range(7));
        xfer(i, 1'b1, pool[i][k], {$urandom, $urandom});
      end
      for (int t = 0; t < 30; t++) begin
        int op;
        op = $urandom_range(2);
        if (op == 0)
          xfer(i, 1'b1, pool[i][$urandom_range(7)], {$urandom, $urandom});
        else if (op == 1)
          xfer(i, 1'b0, pool[i][$urandom_range(7)], 64'h0);
        else
          b2b(i, pool[i][$urandom_range(7)], {$urandom, $urandom}, pool[i][$urandom_range(7)]);
      end
    end

    n = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_data_mem_slave.md
Name: ahb_data_mem_slave

Overview:
- Data-memory responder on the single-master AHB-lite-style bus driven by the load/store stage (HADDR/HTRANS/HWRITE/HWDATA in, HRDATA out).
- Holds a 64-bit-word synchronous RAM and answers one transfer at a time, with configurable wait states and an optional out-of-range error response.
- Sits between the core's memory stage and the data RAM.
- Full 64-bit writes only; byte, half and word stores arrive already merged by the initiator's read-modify-write.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 64-bit words (default 1024 words = 8 KiB).
- BASE_ADDR, 64'h0, byte address of word 0.
- WAIT_STATES, 1, extra HREADY-low cycles inserted in every data phase (0..15).

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST_N  input  1  asynchronous active-low reset.
- HADDR  input  64  byte address, valid in the address phase.
- HTRANS  input  1  1 = transfer request, 0 = idle.
- HWRITE  input  1  1 = write, 0 = read; valid in the address phase.
- HWDATA  input  64  write data; valid in the data phase.
- HRDATA  output  64  read data; valid when HREADY=1 in the data phase of a read.
- HREADY  output  1  1 = data phase completes this cycle / slave can accept an address.
- HRESP  output  1  1 = error response.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter=0, latched addr/write flag cleared. RAM contents are not cleared.
- Reset asserted mid-transfer aborts the transfer; a pending write is not committed.
- Word index = (HADDR - BASE_ADDR) >> 3. HADDR[2:0] is ignored (no alignment check).
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- Address phase: HTRANS=1 sampled at a posedge where HREADY=1 accepts the transfer. Latch index and HWRITE.
  - If WAIT_STATES>0: go to WAIT, counter=WAIT_STATES-1.
  - Otherwise: go to DATA.
  - Out-of-range address (see Optional Feature): go to ERR1.
- WAIT: HREADY=0, HRESP=0. Decrement the counter each cycle; go to DATA when it reaches 0. HTRANS is ignored while HREADY=0.
- DATA: HREADY=1, HRESP=0.
  - Read: HRDATA = RAM[latched index], registered on entry to DATA.
  - Write: RAM[latched index] <= HWDATA at the posedge ending DATA.
  - At that same posedge a new HTRANS=1 is accepted (back-to-back pipelining). Otherwise go to IDLE.
- Read-after-write bypass: if a read address phase is accepted at the same edge that commits a write to the same index, and WAIT_STATES=0, HRDATA takes the forwarded HWDATA.
- ERR1: HREADY=0, HRESP=1. Next cycle go to ERR2.
- ERR2: HREADY=1, HRESP=1. No RAM access; HRDATA=0. A new transfer may be accepted at the ERR2 edge.
- HRDATA holds its last value in IDLE, WAIT and write DATA phases.
- HTRANS=0 in IDLE: no change.
- Latency, read or write: 1 + WAIT_STATES cycles from address acceptance to the HREADY=1 data edge. Error: always 2 cycles.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined: an address below BASE_ADDR or at/above BASE_ADDR + 8*2^DEPTH_LOG2 takes the two-cycle ERR1/ERR2 response. Writes to such addresses are dropped.
- Undefined: no range check; the index wraps modulo 2^DEPTH_LOG2; HRESP is tied 0; ERR1/ERR2 are unreachable and may be omitted.

Test Plan:
- Reset with WAIT_STATES=1: RST_N low for 2 cycles -> HREADY=1, HRESP=0, HRDATA=0. Release -> state IDLE, no RAM write.
- Write then read, WAIT_STATES=1: write 64'hDEADBEEF_CAFEF00D to 0x10, then read 0x10 -> each transfer shows HREADY low for 1 cycle; the read returns HRDATA=64'hDEADBEEF_CAFEF00D on its HREADY=1 cycle.
- Back-to-back with WAIT_STATES=0: write 64'h1234 to 0x8 immediately followed by a read of 0x8 -> the read returns 64'h1234 one cycle after its address phase (bypass path).
- Error, macro defined, 1024 words: read 0x2000 -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE with HRESP=0. A write to 0x2000 leaves RAM unchanged.
- Wrap, macro undefined, 1024 words: write 64'hA5 to 0x2000, then read 0x0 -> 64'hA5; HRESP stays 0 throughout.
- Reset mid-write, WAIT_STATES=3: assert RST_N in the second WAIT cycle of a write of 64'hFF to 0x18 -> a subsequent read of 0x18 returns the prior value, not 64'hFF.
